// File: rtl/rr_mux_arbiter_if.sv
// Request/data bundle and registered grant/select/data returns shared by the four requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_mux_arbiter_if;
    logic [3:0] req;
    logic [3:0] i;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;
    logic       y;

    modport master (
        output req,
        output i,
        input  gnt,
        input  s0,
        input  s1,
        input  busy,
        input  y
    );

    modport slave (
        input  req,
        input  i,
        output gnt,
        output s0,
        output s1,
        output busy,
        output y
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 bit mux with a bounded tenure; grant is one edge after request in IDLE.
// No preemption: non-owners wait, and at least one idle cycle separates any two grants.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_mux_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               y_q, y_d;
    logic [1:0]         win;
    logic [1:0]         idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        win     = ptr_q;
        idx     = 2'd0;

        // Scan from the farthest slot back to ptr so the nearest requester wins last.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (bus.req[idx]) begin
                win = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!bus.req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD - 1))) begin
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        y_d = busy_d ? bus.i[sel_d] : 1'b0;
    end

    assign bus.gnt  = gnt_q;
    assign bus.s0   = sel_q[1];
    assign bus.s1   = sel_q[0];
    assign bus.busy = busy_q;
    assign bus.y    = y_q;
endmodule
